id_ex_register: RTL
===================

ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 clk  input  1  rising-edge clock; every register in the block is clocked on it.
REQ-002 rst  input  1  reset; synchronous and active-high.
REQ-003 stall_E  input  1  when 1, hold all stored fields.
REQ-004 flush_E  input  1  when 1, insert a bubble.
REQ-005 valid_D  input  1  decode slot holds a real instruction.
REQ-006 ctrl_register_file_WE_D, ctrl_srcB_D, ctrl_register_file_WA_D, ctrl_data_memory_WE_D, ctrl_result_D, branch_D  input  1 each  decode control bits.
REQ-007 ctrl_ALU_D  input  4  ALU operation select.
REQ-008 RD1_D, RD2_D, imm_ext_D, PC_D, PC_plus4_D  input  32 each  operands, extended immediate and PCs.
REQ-009 rs1_D, rs2_D, rd_D  input  5 each  register addresses.
REQ-010 Every "_D" input SHALL have a matching "_E" output of the same width, plus valid_E (1 bit).
REQ-011 bubble_count  output  32  count of bubbles delivered to execute.
REQ-012 instr_count  output  32  count of valid instructions delivered to execute.

Function
REQ-013 All "_E" outputs and both counters SHALL be registered, with no combinational path from any input to any output.
REQ-014 Each cycle, the block SHALL apply exactly one of the following actions, in priority order: rst, flush_E, stall_E, load.
REQ-015 Load: on each rising edge with rst=0, flush_E=0 and stall_E=0, every "_E" output SHALL take its "_D" input, giving 1-cycle latency.
REQ-016 Stall: when stall_E=1 and flush_E=0, all "_E" outputs and both counters SHALL hold their values.
REQ-017 Flush: when flush_E=1, the block SHALL clear valid_E, ctrl_register_file_WE_E, ctrl_data_memory_WE_E and branch_E to 0, and SHALL clear all other "_E" fields to 0, regardless of stall_E.
REQ-018 Masking: when valid_D=0 is loaded, ctrl_register_file_WE_E, ctrl_data_memory_WE_E and branch_E SHALL be forced to 0, and datapath fields SHALL load normally.
REQ-019 bubble_count SHALL increment by 1 on each edge where a flush occurs or a load occurs with valid_D=0.
REQ-020 instr_count SHALL increment by 1 on each edge where a load occurs with valid_D=1.
REQ-021 Both counters SHALL saturate at 0xFFFFFFFF and never wrap.
REQ-022 A stalled cycle SHALL increment neither counter.
REQ-023 At most one counter SHALL increment per cycle.
REQ-024 A flush and a stall in the same cycle SHALL count as one bubble.

Reset
REQ-025 When rst=1 at a rising edge, all "_E" outputs, valid_E, bubble_count and instr_count SHALL become 0 on that edge, regardless of stall_E, flush_E or valid_D.
REQ-026 Reset asserted mid-stall SHALL discard the held instruction.
REQ-027 The first load after reset deasserts SHALL occur on the next edge with rst=0.
REQ-028 Reset SHALL not increment either counter.

Verification
REQ-029 Load: rst, then valid_D=1, RD1_D=0x12345678, rd_D=5, ctrl_register_file_WE_D=1, ctrl_ALU_D=4'b0010 -> after 1 edge these appear on the "_E" outputs, valid_E=1, instr_count=1.
REQ-030 Stall: load RD1_D=0xA, then hold stall_E=1 for 3 edges while RD1_D=0xB -> RD1_E stays 0xA and both counters are unchanged; stall_E=0 -> next edge RD1_E=0xB.
REQ-031 Flush with stall: flush_E=1 and stall_E=1 together, valid_D=1, ctrl_data_memory_WE_D=1 -> next edge valid_E=0, ctrl_data_memory_WE_E=0, all fields 0, bubble_count +1.
REQ-032 Invalid decode: valid_D=0, branch_D=1, ctrl_register_file_WE_D=1, PC_D=0x100 -> branch_E=0, ctrl_register_file_WE_E=0, PC_E=0x100, bubble_count +1.
REQ-033 Saturation: preload bubble_count to 0xFFFFFFFE via a forced state, apply 3 flushes -> bubble_count reads 0xFFFFFFFF and stays there.
REQ-034 Reset mid-operation: mid-stall with valid_E=1, pulse rst=1 for 1 edge -> all outputs and counters 0; next edge loads the "_D" inputs.

Source files
------------

// File: rtl/id_ex_register_if.sv
// ID/EX pipeline bundle: decode-side fields in, execute-side fields
// and the bubble/instruction counters out.
interface id_ex_register_if;
    // Decode-side fields
    logic        valid_D;
    logic        ctrl_register_file_WE_D;
    logic        ctrl_srcB_D;
    logic        ctrl_register_file_WA_D;
    logic        ctrl_data_memory_WE_D;
    logic        ctrl_result_D;
    logic        branch_D;
    logic [3:0]  ctrl_ALU_D;
    logic [31:0] RD1_D;
    logic [31:0] RD2_D;
    logic [31:0] imm_ext_D;
    logic [31:0] PC_D;
    logic [31:0] PC_plus4_D;
    logic [4:0]  rs1_D;
    logic [4:0]  rs2_D;
    logic [4:0]  rd_D;

    // Execute-side fields
    logic        valid_E;
    logic        ctrl_register_file_WE_E;
    logic        ctrl_srcB_E;
    logic        ctrl_register_file_WA_E;
    logic        ctrl_data_memory_WE_E;
    logic        ctrl_result_E;
    logic        branch_E;
    logic [3:0]  ctrl_ALU_E;
    logic [31:0] RD1_E;
    logic [31:0] RD2_E;
    logic [31:0] imm_ext_E;
    logic [31:0] PC_E;
    logic [31:0] PC_plus4_E;
    logic [4:0]  rs1_E;
    logic [4:0]  rs2_E;
    logic [4:0]  rd_E;

    // Statistics
    logic [31:0] bubble_count;
    logic [31:0] instr_count;

    // Decode stage side: drives the _D fields, observes the _E fields
    modport master (
        output valid_D, ctrl_register_file_WE_D, ctrl_srcB_D, ctrl_register_file_WA_D,
               ctrl_data_memory_WE_D, ctrl_result_D, branch_D, ctrl_ALU_D,
               RD1_D, RD2_D, imm_ext_D, PC_D, PC_plus4_D, rs1_D, rs2_D, rd_D,
        input  valid_E, ctrl_register_file_WE_E, ctrl_srcB_E, ctrl_register_file_WA_E,
               ctrl_data_memory_WE_E, ctrl_result_E, branch_E, ctrl_ALU_E,
               RD1_E, RD2_E, imm_ext_E, PC_E, PC_plus4_E, rs1_E, rs2_E, rd_E,
               bubble_count, instr_count
    );

    // Pipeline register side: consumes the _D fields, produces the _E fields
    modport slave (
        input  valid_D, ctrl_register_file_WE_D, ctrl_srcB_D, ctrl_register_file_WA_D,
               ctrl_data_memory_WE_D, ctrl_result_D, branch_D, ctrl_ALU_D,
               RD1_D, RD2_D, imm_ext_D, PC_D, PC_plus4_D, rs1_D, rs2_D, rd_D,
        output valid_E, ctrl_register_file_WE_E, ctrl_srcB_E, ctrl_register_file_WA_E,
               ctrl_data_memory_WE_E, ctrl_result_E, branch_E, ctrl_ALU_E,
               RD1_E, RD2_E, imm_ext_E, PC_E, PC_plus4_E, rs1_E, rs2_E, rd_E,
               bubble_count, instr_count
    );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall, flush (bubble insertion), masking of
// side-effecting controls for invalid decode slots, and saturating
// bubble/instruction counters. Everything visible downstream is registered.
module id_ex_register (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_E,
    input  logic              flush_E,
    id_ex_register_if.slave   bus
);

    // One action per edge, chosen in strict priority order
    typedef enum logic [1:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_STALL,
        ACT_LOAD
    } action_e;

    action_e action;

    logic        valid_q,   valid_d;
    logic        rfWe_q,    rfWe_d;
    logic        srcB_q,    srcB_d;
    logic        rfWa_q,    rfWa_d;
    logic        dmWe_q,    dmWe_d;
    logic        result_q,  result_d;
    logic        branch_q,  branch_d;
    logic [3:0]  alu_q,     alu_d;
    logic [31:0] rd1_q,     rd1_d;
    logic [31:0] rd2_q,     rd2_d;
    logic [31:0] imm_q,     imm_d;
    logic [31:0] pc_q,      pc_d;
    logic [31:0] pcPlus4_q, pcPlus4_d;
    logic [4:0]  rs1_q,     rs1_d;
    logic [4:0]  rs2_q,     rs2_d;
    logic [4:0]  rd_q,      rd_d;

    logic [31:0] bubble_count_q, bubble_count_d;
    logic [31:0] instr_count_q,  instr_count_d;

    logic bubbleInc;
    logic instrInc;

    // Pick the single action for this edge: reset beats flush beats stall beats load
    always_comb begin
        action = ACT_LOAD;
        if (rst) begin
            action = ACT_RESET;
        end else if (flush_E) begin
            action = ACT_FLUSH;
        end else if (stall_E) begin
            action = ACT_STALL;
        end
    end

    // Next value of every stage field; an invalid slot loads its datapath but never its side effects
    always_comb begin
        valid_d   = valid_q;
        rfWe_d    = rfWe_q;
        srcB_d    = srcB_q;
        rfWa_d    = rfWa_q;
        dmWe_d    = dmWe_q;
        result_d  = result_q;
        branch_d  = branch_q;
        alu_d     = alu_q;
        rd1_d     = rd1_q;
        rd2_d     = rd2_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        pcPlus4_d = pcPlus4_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;

        unique case (action)
            ACT_RESET, ACT_FLUSH: begin
                valid_d   = 1'b0;
                rfWe_d    = 1'b0;
                srcB_d    = 1'b0;
                rfWa_d    = 1'b0;
                dmWe_d    = 1'b0;
                result_d  = 1'b0;
                branch_d  = 1'b0;
                alu_d     = 4'd0;
                rd1_d     = 32'd0;
                rd2_d     = 32'd0;
                imm_d     = 32'd0;
                pc_d      = 32'd0;
                pcPlus4_d = 32'd0;
                rs1_d     = 5'd0;
                rs2_d     = 5'd0;
                rd_d      = 5'd0;
            end
            ACT_STALL: begin
            end
            ACT_LOAD: begin
                valid_d   = bus.valid_D;
                rfWe_d    = bus.ctrl_register_file_WE_D & bus.valid_D;
                srcB_d    = bus.ctrl_srcB_D;
                rfWa_d    = bus.ctrl_register_file_WA_D;
                dmWe_d    = bus.ctrl_data_memory_WE_D & bus.valid_D;
                result_d  = bus.ctrl_result_D;
                branch_d  = bus.branch_D & bus.valid_D;
                alu_d     = bus.ctrl_ALU_D;
                rd1_d     = bus.RD1_D;
                rd2_d     = bus.RD2_D;
                imm_d     = bus.imm_ext_D;
                pc_d      = bus.PC_D;
                pcPlus4_d = bus.PC_plus4_D;
                rs1_d     = bus.rs1_D;
                rs2_d     = bus.rs2_D;
                rd_d      = bus.rd_D;
            end
            default: begin
            end
        endcase
    end

    // Counter steering: a flush (even with stall) or an invalid load is a bubble, a valid load is an instruction
    always_comb begin
        bubbleInc = (action == ACT_FLUSH) || ((action == ACT_LOAD) && !bus.valid_D);
        instrInc  = (action == ACT_LOAD) && bus.valid_D;

        bubble_count_d = bubble_count_q;
        instr_count_d  = instr_count_q;

        if (action == ACT_RESET) begin
            bubble_count_d = 32'd0;
            instr_count_d  = 32'd0;
        end else begin
            if (bubbleInc && (bubble_count_q != 32'hFFFF_FFFF)) begin
                bubble_count_d = bubble_count_q + 32'd1;
            end
            if (instrInc && (instr_count_q != 32'hFFFF_FFFF)) begin
                instr_count_d = instr_count_q + 32'd1;
            end
        end
    end

    // Stage field register; reset is folded into the next-state logic so it is synchronous
    always_ff @(posedge clk) begin
        valid_q   <= valid_d;
        rfWe_q    <= rfWe_d;
        srcB_q    <= srcB_d;
        rfWa_q    <= rfWa_d;
        dmWe_q    <= dmWe_d;
        result_q  <= result_d;
        branch_q  <= branch_d;
        alu_q     <= alu_d;
        rd1_q     <= rd1_d;
        rd2_q     <= rd2_d;
        imm_q     <= imm_d;
        pc_q      <= pc_d;
        pcPlus4_q <= pcPlus4_d;
        rs1_q     <= rs1_d;
        rs2_q     <= rs2_d;
        rd_q      <= rd_d;
    end

    // Counter register
    always_ff @(posedge clk) begin
        bubble_count_q <= bubble_count_d;
        instr_count_q  <= instr_count_d;
    end

    assign bus.valid_E                 = valid_q;
    assign bus.ctrl_register_file_WE_E = rfWe_q;
    assign bus.ctrl_srcB_E             = srcB_q;
    assign bus.ctrl_register_file_WA_E = rfWa_q;
    assign bus.ctrl_data_memory_WE_E   = dmWe_q;
    assign bus.ctrl_result_E           = result_q;
    assign bus.branch_E                = branch_q;
    assign bus.ctrl_ALU_E              = alu_q;
    assign bus.RD1_E                   = rd1_q;
    assign bus.RD2_E                   = rd2_q;
    assign bus.imm_ext_E               = imm_q;
    assign bus.PC_E                    = pc_q;
    assign bus.PC_plus4_E              = pcPlus4_q;
    assign bus.rs1_E                   = rs1_q;
    assign bus.rs2_E                   = rs2_q;
    assign bus.rd_E                    = rd_q;
    assign bus.bubble_count            = bubble_count_q;
    assign bus.instr_count             = instr_count_q;

endmodule
